// File: rtl/fir_pkg.sv
// Shared constants and round/saturate helper for the FIR output stages.
package fir_pkg;

  localparam int unsigned DEF_IN_W  = 16;
  localparam int unsigned DEF_OUT_W = 8;
  localparam int          SAT_MAX   = (2 ** (DEF_OUT_W - 1)) - 1;
  localparam int          SAT_MIN   = -(2 ** (DEF_OUT_W - 1));

  // Wide enough that adding the rounding constant never overflows.
  localparam int unsigned CALC_W = 32;

  typedef struct packed {
    logic                     sat;
    logic signed [CALC_W-1:0] val;
  } rs_res_t;

  // Round half up, shift right arithmetically, then clamp to out_w signed bits.
  function automatic rs_res_t round_sat(input logic signed [CALC_W-1:0] x,
                                        input int unsigned shift,
                                        input int unsigned out_w);
    logic signed [CALC_W-1:0] t;
    logic signed [CALC_W-1:0] r;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    rs_res_t                  res;
    t  = x + (32'sd1 <<< (shift - 32'd1));
    r  = t >>> shift;
    hi = (32'sd1 <<< (out_w - 32'd1)) - 32'sd1;
    lo = -hi - 32'sd1;
    res.sat = 1'b0;
    res.val = r;
    if (r > hi) begin
      res.sat = 1'b1;
      res.val = hi;
    end else if (r < lo) begin
      res.sat = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_stage_if.sv
// Producer/consumer signal bundle of fir_out_stage.
interface fir_out_stage_if
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [LVL_W-1:0]        level;
  logic                    sat_flag;
  logic                    ovf_flag;
  logic                    clr_flags;

  modport master (
    output in_valid, in_data, out_ready, clr_flags,
    input  out_valid, out_data, level, sat_flag, ovf_flag
  );

  modport slave (
    input  in_valid, in_data, out_ready, clr_flags,
    output out_valid, out_data, level, sat_flag, ovf_flag
  );
endinterface

// File: rtl/fir_out_fifo.sv
// Circular-buffer FIFO; a push while full is only honoured alongside a pop.
module fir_out_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + LVL_W'(1);
      else if (do_pop && !do_push) count <= count - LVL_W'(1);
    end
  end

endmodule

// File: rtl/fir_out_stage.sv
// Rescales, decimates and buffers FIR results for a valid/ready consumer.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned SHIFT = 7,
  parameter int unsigned DECIM = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  fir_out_stage_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CNT_W-1:0] dec_cnt;
  logic             keep;
  rs_res_t          cond;
  logic             unused_hi;
  logic             stg_vld;
  logic [OUT_W-1:0] stg_data;
  logic             sat_q;
  logic             ovf_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] head;
  logic [LVL_W-1:0] fifo_level;
  logic             pop;
  logic             push;
  logic             drop;

  assign keep      = bus.in_valid && (dec_cnt == '0);
  assign cond      = round_sat(CALC_W'(bus.in_data), SHIFT, OUT_W);
  assign unused_hi = ^cond.val[CALC_W-1:OUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (bus.in_valid) begin
      dec_cnt <= (dec_cnt == CNT_W'(DECIM - 1)) ? '0 : dec_cnt + CNT_W'(1);
    end
  end

  // Stage register: the conditioned sample enters the FIFO one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld  <= 1'b0;
      stg_data <= '0;
    end else begin
      stg_vld <= keep;
      if (keep) stg_data <= cond.val[OUT_W-1:0];
    end
  end

  // The FIR cannot stall: a full FIFO without a concurrent pop drops the sample.
  assign pop  = !fifo_empty && bus.out_ready;
  assign push = stg_vld && (!fifo_full || pop);
  assign drop = stg_vld && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (keep && cond.sat)  sat_q <= 1'b1;
      else if (bus.clr_flags) sat_q <= 1'b0;
      if (drop)               ovf_q <= 1'b1;
      else if (bus.clr_flags) ovf_q <= 1'b0;
    end
  end

  fir_out_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (stg_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : head;
  assign bus.level     = fifo_level;
  assign bus.sat_flag  = sat_q;
  assign bus.ovf_flag  = ovf_q;

endmodule

// File: tb/tb_fir_out_stage.sv
// Drives a DECIM=1 and a DECIM=2 instance and checks both against a queue model.
module tb_fir_out_stage;
  import fir_pkg::*;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SHIFT = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_out_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) b0 ();
  fir_out_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) b1 ();

  fir_out_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(1), .DEPTH(DEPTH))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  fir_out_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(2), .DEPTH(DEPTH))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  int npass, ntot, nfail;

  // Reference model state, index 0 -> u0, 1 -> u1
  int mq0[$];
  int mq1[$];
  int mcnt[2];
  bit mstg_v[2];
  int mstg_d[2];
  bit msat[2];
  bit movf[2];

  bit iv[2];
  int id[2];
  bit ordy[2];
  bit clr[2];

  function automatic int dec(int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // floor((x + 2^(SHIFT-1)) / 2^SHIFT) with ordinary integer division
  function automatic int ref_round(int x);
    int v;
    int dv;
    dv = 1 << SHIFT;
    v  = x + (dv / 2);
    if (v >= 0) return v / dv;
    return -((-v + dv - 1) / dv);
  endfunction

  function automatic int ref_clamp(int r);
    if (r > 127) return 127;
    if (r < -128) return -128;
    return r;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int qfront(int d);
    if (qsize(d) == 0) return 0;
    return (d == 0) ? mq0[0] : mq1[0];
  endfunction

  task automatic qpop(int d);
    if (d == 0) void'(mq0.pop_front());
    else        void'(mq1.pop_front());
  endtask

  task automatic qpush(int d, int v);
    if (d == 0) mq0.push_back(v);
    else        mq1.push_back(v);
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0; mstg_v[d] = 0; mstg_d[d] = 0; msat[d] = 0; movf[d] = 0;
    end
  endtask

  task automatic model_edge(int d);
    bit pop;
    bit accept;
    bit keep;
    int r;
    pop    = (qsize(d) > 0) && ordy[d];
    accept = mstg_v[d] && ((qsize(d) < int'(DEPTH)) || pop);
    if (mstg_v[d] && !accept) movf[d] = 1;
    else if (clr[d])          movf[d] = 0;
    if (pop)    qpop(d);
    if (accept) qpush(d, mstg_d[d]);
    keep = iv[d] && (mcnt[d] == 0);
    r    = ref_round(id[d]);
    if (keep && (r != ref_clamp(r))) msat[d] = 1;
    else if (clr[d])                 msat[d] = 0;
    mstg_v[d] = keep;
    mstg_d[d] = ref_clamp(r);
    if (iv[d]) mcnt[d] = (mcnt[d] + 1) % dec(d);
  endtask

  task automatic chk(string tag, int obs, int exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("u0.out_valid", int'(b0.out_valid), int'(qsize(0) > 0));
    chk("u0.out_data",  int'(b0.out_data),  qfront(0));
    chk("u0.level",     int'(b0.level),     qsize(0));
    chk("u0.sat_flag",  int'(b0.sat_flag),  int'(msat[0]));
    chk("u0.ovf_flag",  int'(b0.ovf_flag),  int'(movf[0]));
    chk("u1.out_valid", int'(b1.out_valid), int'(qsize(1) > 0));
    chk("u1.out_data",  int'(b1.out_data),  qfront(1));
    chk("u1.level",     int'(b1.level),     qsize(1));
    chk("u1.sat_flag",  int'(b1.sat_flag),  int'(msat[1]));
    chk("u1.ovf_flag",  int'(b1.ovf_flag),  int'(movf[1]));
  endtask

  task automatic drive();
    b0.in_valid = iv[0]; b0.in_data = IN_W'(id[0]); b0.out_ready = ordy[0]; b0.clr_flags = clr[0];
    b1.in_valid = iv[1]; b1.in_data = IN_W'(id[1]); b1.out_ready = ordy[1]; b1.clr_flags = clr[1];
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    if (!rst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    compare_all();
  endtask

  // Asynchronous reset applied with whatever inputs are currently driven
  task automatic mid_reset();
    drive();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; id[d] = 0; ordy[d] = 0; clr[d] = 0;
    end
    mid_reset();
  endtask

  int rnd_in[4]  = '{64, 63, -64, -65};
  int rnd_exp[4] = '{1, 0, 0, -1};
  int ovf_exp[4] = '{0, 2, 4, 6};

  initial begin
    npass = 0; ntot = 0; nfail = 0;
    rst = 1'b1;
    model_reset();
    do_reset();
    chk("rst_valid", int'(b1.out_valid), 0);
    chk("rst_data",  int'(b1.out_data), 0);
    chk("rst_level", int'(b1.level), 0);
    chk("rst_flags", int'({b1.sat_flag, b1.ovf_flag, b0.sat_flag, b0.ovf_flag}), 0);

    // DECIM=1 rounding
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; id[0] = rnd_in[i]; tick();
    end
    iv[0] = 0; tick();
    chk("round_level", int'(b0.level), 4);
    chk("round_sat", int'(b0.sat_flag), 0);
    ordy[0] = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("round_out%0d", i), int'(b0.out_data), rnd_exp[i]);
      tick();
    end
    ordy[0] = 0;

    // DECIM=1 saturation and flag clear
    do_reset();
    iv[0] = 1; id[0] = 32767;  tick();
    id[0] = -32768; tick();
    iv[0] = 0; tick();
    chk("sat_flag_set", int'(b0.sat_flag), 1);
    ordy[0] = 1;
    chk("sat_hi", int'(b0.out_data), 127); tick();
    chk("sat_lo", int'(b0.out_data), -128); tick();
    ordy[0] = 0; clr[0] = 1; tick();
    clr[0] = 0;
    chk("sat_flag_clr", int'(b0.sat_flag), 0);

    // DECIM=2 selection and latency
    do_reset();
    ordy[1] = 1; iv[1] = 1;
    id[1] = 128; tick();
    chk("d2_lat_v0", int'(b1.out_valid), 0);
    id[1] = 256; tick();
    chk("d2_lat_v1", int'(b1.out_valid), 1);
    chk("d2_first", int'(b1.out_data), 1);
    id[1] = 384; tick();
    chk("d2_skip", int'(b1.out_valid), 0);
    id[1] = 512; tick();
    chk("d2_second", int'(b1.out_data), 3);
    iv[1] = 0; tick();
    chk("d2_done", int'(b1.level), 0);

    // Overflow with stalled consumer
    do_reset();
    for (int i = 0; i < 10; i++) begin
      iv[1] = 1; id[1] = 128 * i; tick();
    end
    iv[1] = 0; tick();
    chk("ovf_level", int'(b1.level), 4);
    chk("ovf_flag", int'(b1.ovf_flag), 1);
    ordy[1] = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain%0d", i), int'(b1.out_data), ovf_exp[i]);
      tick();
    end
    chk("ovf_empty", int'(b1.out_valid), 0);
    ordy[1] = 0; clr[1] = 1; tick();
    clr[1] = 0;

    // Full FIFO written in the same cycle as a pop
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      iv[0] = 1; id[0] = 128 * k; tick();
    end
    iv[0] = 0;
    chk("fp_full", int'(b0.level), 4);
    ordy[0] = 1; tick();
    chk("fp_level", int'(b0.level), 4);
    chk("fp_no_ovf", int'(b0.ovf_flag), 0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("fp_order%0d", k), int'(b0.out_data), k);
      tick();
    end
    ordy[0] = 0;

    // Reset while three samples are buffered and input is still streaming
    do_reset();
    iv[1] = 1;
    id[1] = 32767; tick();
    id[1] = 0;     tick();
    id[1] = 256;   tick();
    id[1] = 0;     tick();
    id[1] = 512;   tick();
    iv[1] = 0;     tick();
    chk("mr_level3", int'(b1.level), 3);
    chk("mr_sat", int'(b1.sat_flag), 1);
    iv[1] = 1; id[1] = 1000;
    mid_reset();
    chk("mr_level0", int'(b1.level), 0);
    chk("mr_valid0", int'(b1.out_valid), 0);
    chk("mr_flags0", int'({b1.sat_flag, b1.ovf_flag}), 0);
    id[1] = 384; tick();
    id[1] = 640; tick();
    chk("mr_first", int'(b1.out_data), 3);
    iv[1] = 0; tick();

    // Randomised traffic on both instances
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom_range(0, 3) != 0);
        id[d]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                             : int'($urandom_range(0, 2047)) - 1024;
        ordy[d] = (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
        clr[d]  = ($urandom_range(0, 15) == 0);
      end
      if (c == 250) mid_reset();
      else          tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
